vmem_map: RTL
=============

VMEM_MAP -- requirements
Module: vmem_map

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, which sets the map index width; depth is 2^ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 5, which sets the map entry width.
REQ-003 SHALL have parameter INIT_VALUE, default all-ones of DATA_WIDTH (the level-1 "map invalid" code), which is the value written by the clear sequencer.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port mapi, input, ADDR_WIDTH bits: the map index (read and write address).
REQ-007 SHALL have port wdata, input, DATA_WIDTH bits: the write data.
REQ-008 SHALL have port rp, input, 1 bit: read pulse.
REQ-009 SHALL have port wp, input, 1 bit: write pulse.
REQ-010 SHALL have port clear, input, 1 bit: request to re-initialise the whole map.
REQ-011 SHALL have port vmap, output, DATA_WIDTH bits: registered read data.
REQ-012 SHALL have port vmap_vld, output, 1 bit: one-cycle strobe, high when vmap was updated by a read.
REQ-013 SHALL have port busy, output, 1 bit: high while the clear sequencer owns the RAM.

Function
REQ-014 SHALL hold a 2^ADDR_WIDTH x DATA_WIDTH RAM with one synchronous port; no asynchronous read.
REQ-015 SHALL implement a state machine with two states, CLEAR and IDLE.
REQ-016 In CLEAR, SHALL write INIT_VALUE to the address in an ADDR_WIDTH-bit clear counter, one entry per cycle, then increment the counter.
REQ-017 SHALL go from CLEAR to IDLE in the cycle after the write to address 2^ADDR_WIDTH-1, so a clear lasts exactly 2^ADDR_WIDTH cycles with busy high.
REQ-018 In CLEAR, SHALL ignore rp, wp and clear; no RAM access from those inputs, vmap unchanged, vmap_vld low.
REQ-019 In IDLE, clear=1 SHALL move to CLEAR with the counter at 0; clear has priority over rp/wp asserted in the same cycle, and those are dropped.
REQ-020 In IDLE, wp=1 SHALL write wdata to RAM[mapi] at that clock edge.
REQ-021 In IDLE, rp=1 in cycle N SHALL load vmap with RAM[mapi] at the end of cycle N and drive vmap_vld high in cycle N+1 only; read latency is 1.
REQ-022 A write in cycle N followed by a read of the same address in cycle N+1 SHALL return the written data.
REQ-023 rp and wp together on the same address SHALL be resolved per Configuration REQ-028/029; on different addresses both SHALL complete in that cycle.
REQ-024 vmap SHALL hold its last value whenever no read completes, including across a clear.
REQ-025 busy SHALL be registered and equal to (state == CLEAR).

Reset
REQ-026 reset=0 at a clock edge SHALL set state=CLEAR, clear counter=0, vmap=0, vmap_vld=0, busy=1; RAM contents are not reset directly but are overwritten by the clear that follows.
REQ-027 reset asserted mid-clear or mid-operation SHALL restart the clear from address 0; a pending read strobe is discarded.

Configuration
REQ-028 With macro VMEM_MAP_BYPASS_EN defined, a simultaneous rp and wp to the same mapi SHALL return wdata on vmap (write-first), with vmap_vld high the next cycle.
REQ-029 Without VMEM_MAP_BYPASS_EN, the same case SHALL return the old RAM contents (read-first); the RAM still takes wdata.

Verification
REQ-030 Release reset with defaults -> busy=1 for exactly 2048 cycles, then 0; rp at mapi=0x000 and at 0x7FF -> vmap=5'h1F, vmap_vld one cycle.
REQ-031 After init: wp mapi=0x123 wdata=5'h0A; next cycle rp mapi=0x123 -> vmap=5'h0A, vmap_vld pulse 1 cycle later.
REQ-032 mapi=0x055 holds 5'h03; rp+wp same cycle with wdata=5'h11 -> vmap=5'h11 with BYPASS_EN, 5'h03 without; a later read returns 5'h11 in both builds.
REQ-033 Write 5'h07 to 0x010, then clear pulse together with rp -> no vmap_vld, busy 2048 cycles, rp during busy ignored, and a read afterwards returns 5'h1F.
REQ-034 reset=0 for one cycle at clear counter=1000 -> busy stays high for 2048 further cycles, vmap=0.
REQ-035 ADDR_WIDTH=4, DATA_WIDTH=8, INIT_VALUE=8'hA5 -> clear lasts 16 cycles, and all 16 entries read back 8'hA5.

Source files
------------

// File: rtl/vmem_map.sv
// vmem_map: 2^ADDR_WIDTH x DATA_WIDTH map RAM with a self-clearing sequencer.
//
// Parameters
//   ADDR_WIDTH - map index width, depth = 2^ADDR_WIDTH
//   DATA_WIDTH - map entry width
//   INIT_VALUE - value written to every entry by the clear sequencer
//
// Ports
//   clk      - clock, all logic on the rising edge
//   reset    - synchronous active-low reset; starts a full clear
//   mapi     - map index (read and write address)
//   wdata    - write data
//   rp / wp  - read / write pulses, honoured only when idle
//   clear    - request a full re-initialisation of the map
//   vmap     - registered read data, holds until the next completed read
//   vmap_vld - one-cycle strobe, vmap updated by a read
//   busy     - high while the clear sequencer owns the RAM
//
// Build option: define VMEM_MAP_BYPASS_EN to make a simultaneous read and
// write of the same index return the new data (write-first). Without it the
// read returns the previous contents (read-first).
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_CLEAR | sequencer writes INIT_VALUE to clr_cnt, one entry per cycle
// S_IDLE  | RAM available to rp/wp; clear restarts the sequencer

module vmem_map #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] mapi,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rp,
  input  logic                  wp,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] vmap,
  output logic                  vmap_vld,
  output logic                  busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wd;
  logic [DATA_WIDTH-1:0] rd_data;

  // clear in IDLE wins over rp/wp in the same cycle
  assign wr_en = (state == S_IDLE) && !clear && wp;

  // Single RAM port: the sequencer owns address and data while clearing.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = mapi;
    ram_wd   = wdata;
    if (reset) begin
      if (state == S_CLEAR) begin
        ram_we   = 1'b1;
        ram_addr = clr_cnt;
        ram_wd   = INIT_VALUE;
      end else begin
        ram_we = wr_en;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wd;
  end

`ifdef VMEM_MAP_BYPASS_EN
  assign rd_data = wr_en ? wdata : mem[ram_addr];
`else
  // non-blocking RAM update means this sees the pre-write contents
  assign rd_data = mem[ram_addr];
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_CLEAR;
      clr_cnt  <= '0;
      vmap     <= '0;
      vmap_vld <= 1'b0;
      busy     <= 1'b1;
    end else begin
      vmap_vld <= 1'b0;
      case (state)
        S_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (&clr_cnt) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (clear) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
          end else if (rp) begin
            vmap     <= rd_data;
            vmap_vld <= 1'b1;
          end
        end
        default: begin
          state <= S_CLEAR;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule
